fix_to_flt_engine: RTL
======================

# fix_to_flt_engine

Hardware stage downstream of the float-to-fix 8.8 program: after `top_level` writes its signed 8.8 fixed-point result into data memory, this engine reads that word, converts it to IEEE-754 half precision (truncation, no rounding) and writes the result back to data memory. It uses the same start/ack handshake as `top_level` and a byte-wide port into the shared data memory (`mem_core`). It is a multi-cycle FSM with a one-bit-per-cycle normalizer.

## Interface
- `SRC_ADDR`, default 6: byte address of the fixed-point low byte; the high byte is at `SRC_ADDR+1`.
- `DST_ADDR`, default 8: byte address of the half-float low byte; the high byte is at `DST_ADDR+1`.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  request pulse, sampled on the rising edge.
- `ack`  out  1  registered; high while the conversion is complete.
- `mem_addr`  out  8  data-memory byte address (decoded from state).
- `mem_we`  out  1  data-memory write enable (decoded from state).
- `mem_wdata`  out  8  write data.
- `mem_rdata`  in  8  read data; asynchronous read, valid in the same cycle as `mem_addr`.

## Operation
- States: IDLE, RD_LO, RD_HI, ABS, NORM, WR_LO, WR_HI, DONE.
- IDLE or DONE with `start`=1 → RD_LO, and `ack` clears. `start` is ignored in every other state.
- RD_LO: `mem_addr`=SRC_ADDR and the byte is latched into `fix[7:0]`. RD_HI: `mem_addr`=SRC_ADDR+1 and the byte is latched into `fix[15:8]`.
- ABS:
  - `sgn`=`fix[15]`.
  - `mag` (16-bit unsigned) = `sgn ? -fix : fix`, so 0x8000 gives mag 0x8000.
  - `zero`=(fix==0).
  - `cnt`=0.
- NORM, evaluated each cycle:
  - If `zero` or `mag[15]`=1: go to WR_LO.
  - Otherwise: `mag`<<=1, `cnt`++, and stay in NORM.
  - Final `cnt`=s, in the range 0..15.
- Result:
  - If `zero`: result is 0x0000, with the sign forced to 0.
  - Otherwise: {`sgn`, 5'(22−s), `mag[14:5]`}. The unbiased exponent is 7−s. `mag[4:0]` is discarded (truncation).
  - The exponent range is 7..22, so no denormal, infinity or overflow cases exist.
- WR_LO: `mem_addr`=DST_ADDR, `mem_we`=1, `mem_wdata`=result[7:0]. WR_HI: `mem_addr`=DST_ADDR+1, `mem_we`=1, `mem_wdata`=result[15:8].
- WR_HI → DONE. DONE holds `ack`=1 until `start` or `reset`.
- Source bytes are never written. Only DST_ADDR and DST_ADDR+1 are ever written.

## Timing
- Reset values and idle outputs:
  - Reset: state=IDLE, `ack`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, internal registers 0.
  - In IDLE and DONE: `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
- Latency: `start` is sampled at edge E0 and `ack` rises after edge E(6+s).
  - Zero input and inputs with s=0 take 6 cycles.
  - The worst case, 0x0001, takes 21 cycles.
- `mem_we` is high for exactly two consecutive cycles per conversion: low byte first, then high byte.
- `start` held high across several cycles launches one conversion. It is re-sampled only in IDLE or DONE, so a still-high `start` in DONE relaunches.
- `reset` mid-operation: back to IDLE the next edge. Any write not yet issued is dropped, and `ack`=0.
- `reset` and `start` high on the same edge: `reset` wins.

## Test plan
- 0x0100 (1.0) → 0x3C00 written at DST (bytes 0x00, 0x3C); `ack` high 13 cycles after `start`.
- 0x0180 (1.5) → 0x3E00; 0xFF00 (−1.0) → 0xBC00; 0x7FFF → 0x57FF (127.9375, truncated); 0x0001 → 0x1C00 with `ack` at 21 cycles.
- 0x0000 → 0x0000 with `ack` at 6 cycles; 0x8000 (−128) → 0xD800 with `ack` at 6 cycles.
- `reset` pulsed during NORM for input 0x0001 → `ack`=0, `mem_we` never asserted, DST bytes unchanged.
- `start` pulsed again in RD_HI → ignored, exactly one write pair. `start` while in DONE → `ack` drops the next cycle and a new result is written.
- Chained check: the 8.8 output at bytes 6/7 from each float-to-fix vector is converted → decoding the half result equals the 8.8 value exactly whenever that value has ≤11 significant bits.

Source files
------------

// File: rtl/fix_to_flt_engine_if.sv
// Start/ack handshake plus byte-wide data-memory port between the 8.8-to-half engine and its host.
// start is a level sampled on every rising edge; it is acted on only while the engine is idle or done.
// ack is registered and stays high from the end of a conversion until the next accepted start or reset.
// mem_rdata must follow mem_addr combinationally (asynchronous read).
interface fix_to_flt_engine_if;
   logic       start;
   logic       ack;
   logic [7:0] mem_addr;
   logic       mem_we;
   logic [7:0] mem_wdata;
   logic [7:0] mem_rdata;
   logic [2:0] state_dbg;

   // Engine side: takes requests, owns the memory port.
   modport slave (
      input  start,
      input  mem_rdata,
      output ack,
      output mem_addr,
      output mem_we,
      output mem_wdata,
      output state_dbg
   );

   // Host/memory side.
   modport master (
      output start,
      output mem_rdata,
      input  ack,
      input  mem_addr,
      input  mem_we,
      input  mem_wdata,
      input  state_dbg
   );
endinterface

// File: rtl/fix_to_flt_engine.sv
// Reads a signed 8.8 word from data memory, converts it to IEEE-754 half (truncating)
// and writes it back; normalizes one bit per cycle.
module fix_to_flt_engine #(
   parameter logic [7:0] SRC_ADDR = 8'd6,
   parameter logic [7:0] DST_ADDR = 8'd8
) (
   input logic               clk,
   input logic               reset,
   fix_to_flt_engine_if.slave bus
);
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RD_LO = 3'd1,
      RD_HI = 3'd2,
      ABS   = 3'd3,
      NORM  = 3'd4,
      WR_LO = 3'd5,
      WR_HI = 3'd6,
      DONE  = 3'd7
   } state_t;

   state_t      state;
   logic [15:0] fix;
   logic [15:0] mag;
   logic [3:0]  cnt;
   logic        sgn;
   logic        zero;
   logic        ack;
   logic [4:0]  exp_field;
   logic [15:0] result;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         fix   <= '0;
         mag   <= '0;
         cnt   <= '0;
         sgn   <= 1'b0;
         zero  <= 1'b0;
         ack   <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (bus.start) begin
                  state <= RD_LO;
                  ack   <= 1'b0;
               end
            end
            RD_LO: begin
               fix[7:0] <= bus.mem_rdata;
               state    <= RD_HI;
            end
            RD_HI: begin
               fix[15:8] <= bus.mem_rdata;
               state     <= ABS;
            end
            ABS: begin
               // Two's-complement negate; 0x8000 maps to itself, which is the correct magnitude.
               sgn   <= fix[15];
               mag   <= fix[15] ? (~fix + 16'd1) : fix;
               zero  <= (fix == 16'd0);
               cnt   <= 4'd0;
               state <= NORM;
            end
            NORM: begin
               if (zero || mag[15]) begin
                  state <= WR_LO;
               end else begin
                  mag <= {mag[14:0], 1'b0};
                  cnt <= cnt + 4'd1;
               end
            end
            WR_LO: state <= WR_HI;
            WR_HI: begin
               state <= DONE;
               ack   <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Leading one sits at bit 15 after normalizing, so the biased exponent is 15 + (7 - cnt).
   assign exp_field = 5'd22 - {1'b0, cnt};
   assign result    = zero ? 16'h0000 : {sgn, exp_field, mag[14:5]};

   always_comb begin
      bus.mem_addr  = 8'd0;
      bus.mem_we    = 1'b0;
      bus.mem_wdata = 8'd0;
      case (state)
         RD_LO: bus.mem_addr = SRC_ADDR;
         RD_HI: bus.mem_addr = SRC_ADDR + 8'd1;
         WR_LO: begin
            bus.mem_addr  = DST_ADDR;
            bus.mem_we    = 1'b1;
            bus.mem_wdata = result[7:0];
         end
         WR_HI: begin
            bus.mem_addr  = DST_ADDR + 8'd1;
            bus.mem_we    = 1'b1;
            bus.mem_wdata = result[15:8];
         end
         default: ;
      endcase
   end

   assign bus.ack       = ack;
   assign bus.state_dbg = state;
endmodule
